instr_reg_scheduler: RTL and testbench

Controller that owns the load and read ports of `instr_register`. It arbitrates two instruction producers onto the single write port and allocates write slots sequentially. On command, it sweeps `read_pointer` over every loaded entry and streams the stored instruction words out to a consumer. It sits between the stimulus/issue logic and `instr_register`, replacing direct testbench drive of `load_en`, `write_pointer` and `read_pointer`.

---
 rtl/instr_reg_scheduler_pkg.sv | 28 ++
 rtl/instr_reg_scheduler_if.sv | 34 +++
 rtl/instr_reg_scheduler_arbiter.sv | 35 +++
 rtl/instr_reg_scheduler.sv | 107 ++++++++++
 tb/tb_instr_reg_scheduler.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_reg_scheduler_pkg.sv
// Shared types and constants for instr_register and its scheduler.
// Depth, operand/opcode/address types and the scheduler state enum.
package instr_register_pkg;

  localparam int INSTR_DEPTH = 32;
  localparam int AW = $clog2(INSTR_DEPTH);

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD,
    SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [AW-1:0] address_t;
  typedef logic [AW:0] count_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } sched_state_t;

endpackage

// File: rtl/instr_reg_scheduler_if.sv
// Two-producer valid/ready request bundle for instr_reg_scheduler.
// master = producers, slave = scheduler.
interface instr_reg_scheduler_if;
  import instr_register_pkg::*;

  logic     req0_valid;
  logic     req0_ready;
  opcode_t  req0_opcode;
  operand_t req0_operand_a;
  operand_t req0_operand_b;

  logic     req1_valid;
  logic     req1_ready;
  opcode_t  req1_opcode;
  operand_t req1_operand_a;
  operand_t req1_operand_b;

  modport master (
    output req0_valid, req0_opcode,
    output req0_operand_a, req0_operand_b,
    output req1_valid, req1_opcode,
    output req1_operand_a, req1_operand_b,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_opcode,
    input  req0_operand_a, req0_operand_b,
    input  req1_valid, req1_opcode,
    input  req1_operand_a, req1_operand_b,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/instr_reg_scheduler_arbiter.sv
// 2-way grant logic for the scheduler write port.
// INSTR_SCHED_RR_EN selects round-robin; otherwise requester 0 wins.
module instr_rr_arbiter (
`ifdef INSTR_SCHED_RR_EN
  input  logic clk,
  input  logic reset_n,
`endif
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef INSTR_SCHED_RR_EN
  logic last_grant;
  logic contend;

  assign contend = en & valid0 & valid1;
  // last_grant = 1 means requester 1 was served last
  assign grant0 = en & valid0 & (~valid1 | last_grant);
  assign grant1 = en & valid1 & (~valid0 | ~last_grant);

  always_ff @(posedge clk) begin
    if (!reset_n)
      last_grant <= 1'b1;
    else if (contend)
      last_grant <= ~last_grant;
  end
`else
  assign grant0 = en & valid0;
  assign grant1 = en & valid1 & ~valid0;
`endif

endmodule

// File: rtl/instr_reg_scheduler.sv
// Load/readback controller for instr_register (IDLE/SWEEP FSM).
// Arbitration mode set by macro INSTR_SCHED_RR_EN.
module instr_reg_scheduler
  import instr_register_pkg::*;
#(
  parameter int DEPTH = INSTR_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_reg_scheduler_if.slave req,
  output logic                 load_en,
  output opcode_t              opcode,
  output operand_t             operand_a,
  output operand_t             operand_b,
  output address_t             write_pointer,
  output address_t             read_pointer,
  input  instruction_t         instruction_word,
  input  logic                 run_start,
  output logic                 rd_valid,
  output instruction_t         rd_instr,
  output address_t             rd_index,
  output logic                 done,
  output count_t               count,
  output logic                 full,
  output logic                 busy
);

  sched_state_t state;
  logic accept;
  logic grant0;
  logic grant1;
  logic last;

  assign full = (count == count_t'(DEPTH));
  assign busy = (state == SWEEP);
  assign accept = reset_n & (state == IDLE)
                & ~full & ~run_start;
  assign last = ({1'b0, read_pointer} == count - count_t'(1));

  instr_rr_arbiter u_arb (
`ifdef INSTR_SCHED_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .en      (accept),
    .valid0  (req.req0_valid),
    .valid1  (req.req1_valid),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  assign req.req0_ready = grant0;
  assign req.req1_ready = grant1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      load_en       <= 1'b0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
      write_pointer <= '0;
      read_pointer  <= '0;
      rd_valid      <= 1'b0;
      rd_instr      <= '0;
      rd_index      <= '0;
      done          <= 1'b0;
      count         <= '0;
    end else begin
      load_en  <= grant0 | grant1;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            opcode        <= grant0 ? req.req0_opcode
                                    : req.req1_opcode;
            operand_a     <= grant0 ? req.req0_operand_a
                                    : req.req1_operand_a;
            operand_b     <= grant0 ? req.req0_operand_b
                                    : req.req1_operand_b;
            write_pointer <= count[AW-1:0];
            count         <= count + count_t'(1);
          end
          if (run_start && count != '0)
            state <= SWEEP;
        end
        SWEEP: begin
          // done is high while the last entry is presented
          if (done) begin
            state        <= IDLE;
            count        <= '0;
            read_pointer <= '0;
          end else begin
            rd_valid <= 1'b1;
            rd_instr <= instruction_word;
            rd_index <= read_pointer;
            done     <= last;
            if (!last)
              read_pointer <= read_pointer + address_t'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Randomized self-checking bench for instr_reg_scheduler.
// Reference model: ordered queue of accepted instructions.
module tb_instr_reg_scheduler;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_reg_scheduler_if bus ();

  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  address_t     write_pointer;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         run_start;
  logic         rd_valid;
  instruction_t rd_instr;
  address_t     rd_index;
  logic         done;
  count_t       count;
  logic         full;
  logic         busy;

  instr_reg_scheduler dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (bus),
    .load_en          (load_en),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .run_start        (run_start),
    .rd_valid         (rd_valid),
    .rd_instr         (rd_instr),
    .rd_index         (rd_index),
    .done             (done),
    .count            (count),
    .full             (full),
    .busy             (busy)
  );

  // Stand-in for instr_register
  instruction_t mem [INSTR_DEPTH];
  always @(posedge clk)
    if (load_en)
      mem[write_pointer] <= {opcode, operand_a, operand_b};
  assign instruction_word = mem[read_pointer];

  int errors = 0;
  int checks = 0;
  instruction_t m_q[$];
  int m_last = 1;
  instruction_t p0, p1;

  // Expected winner; -1 when nobody requests
  function automatic int m_winner(bit v0, bit v1);
    int w;
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
`ifdef INSTR_SCHED_RR_EN
    w = (m_last == 1) ? 0 : 1;
    m_last = w;
`else
    w = 0;
`endif
    return w;
  endfunction

  function automatic instruction_t rnd_instr();
    instruction_t t;
    t.opc  = opcode_t'($urandom_range(0, 7));
    t.op_a = operand_t'($urandom);
    t.op_b = operand_t'($urandom);
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit v0, bit v1);
    bus.req0_valid     = v0;
    bus.req0_opcode    = p0.opc;
    bus.req0_operand_a = p0.op_a;
    bus.req0_operand_b = p0.op_b;
    bus.req1_valid     = v1;
    bus.req1_opcode    = p1.opc;
    bus.req1_operand_a = p1.op_a;
    bus.req1_operand_b = p1.op_b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    run_start = 1'b0;
    drive(0, 0);
    step();
    step();
    reset_n = 1'b1;
    m_q.delete();
    m_last = 1;
  endtask

  task automatic test_reset();
    p0 = rnd_instr();
    p1 = rnd_instr();
    reset_n = 1'b0;
    run_start = 1'b0;
    drive(1, 1);
    step();
    step();
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, load_en,
         rd_valid, done, busy, full} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0",
        {bus.req0_ready, bus.req1_ready, load_en,
         rd_valid, done, busy, full});
    end
    checks++;
    if (count !== count_t'(0)) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if ({write_pointer, read_pointer, rd_index} !== '0) begin
      errors++;
      $display("FAIL reset_ptrs: wp=%0d rp=%0d idx=%0d want 0",
        write_pointer, read_pointer, rd_index);
    end
    checks++;
    if ({operand_a, operand_b, rd_instr} !== '0) begin
      errors++;
      $display("FAIL reset_data: a=%0d b=%0d want 0",
        operand_a, operand_b);
    end
    reset_n = 1'b1;
    drive(0, 0);
    m_q.delete();
    m_last = 1;
    step();
  endtask

  // Readback of everything in m_q, timed from run_start cycle R
  task automatic run_sweep(string tag);
    int n;
    n = m_q.size();
    drive(0, 0);
    run_start = 1'b1;
    #1;
    checks++;
    if (count !== count_t'(n)) begin
      errors++;
      $display("FAIL %s_count_pre: got %0d want %0d",
        tag, count, n);
    end
    step();
    run_start = 1'b0;
    for (int k = 1; k <= n + 2; k++) begin
      #1;
      checks++;
      if (busy !== (k <= n + 1)) begin
        errors++;
        $display("FAIL %s_busy k=%0d: got %b want %b",
          tag, k, busy, (k <= n + 1));
      end
      if (k <= n) begin
        checks++;
        if (read_pointer !== address_t'(k - 1)) begin
          errors++;
          $display("FAIL %s_rp k=%0d: got %0d want %0d",
            tag, k, read_pointer, k - 1);
        end
      end
      checks++;
      if (rd_valid !== (k >= 2 && k <= n + 1)) begin
        errors++;
        $display("FAIL %s_rd_valid k=%0d: got %b",
          tag, k, rd_valid);
      end
      checks++;
      if (done !== (k == n + 1)) begin
        errors++;
        $display("FAIL %s_done k=%0d: got %b want %b",
          tag, k, done, (k == n + 1));
      end
      if (k >= 2 && k <= n + 1) begin
        checks++;
        if (rd_index !== address_t'(k - 2)
            || rd_instr !== m_q[k-2]) begin
          errors++;
          $display("FAIL %s_data k=%0d: idx=%0d %h want %0d %h",
            tag, k, rd_index, rd_instr, k - 2, m_q[k-2]);
        end
      end
      if (k == n + 2) begin
        checks++;
        if (count !== count_t'(0) || full !== 1'b0) begin
          errors++;
          $display("FAIL %s_count_post: got %0d want 0",
            tag, count);
        end
      end
      step();
    end
    m_q.delete();
  endtask

  task automatic test_single();
    do_reset();
    p0.opc = ADD;
    p0.op_a = 5;
    p0.op_b = 3;
    p1 = rnd_instr();
    drive(1, 0);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: got %b want 10",
        {bus.req0_ready, bus.req1_ready});
    end
    m_q.push_back(p0);
    step();
    drive(0, 0);
    #1;
    checks++;
    if (load_en !== 1'b1 || write_pointer !== '0
        || opcode !== ADD || operand_a !== 5
        || operand_b !== 3 || count !== count_t'(1)) begin
      errors++;
      $display("FAIL single_load: le=%b wp=%0d op=%0d a=%0d b=%0d cnt=%0d",
        load_en, write_pointer, opcode, operand_a,
        operand_b, count);
    end
    step();
    run_sweep("single");
  endtask

  task automatic test_contention();
    int w;
    int pw;
    instruction_t pe;
    do_reset();
    pw = -1;
    pe = '0;
    for (int i = 0; i <= 4; i++) begin
      p0 = rnd_instr();
      p1 = rnd_instr();
      drive(i < 4, i < 4);
      #1;
      w = (i < 4) ? m_winner(1, 1) : -1;
      if (i < 4) begin
        checks++;
        if ({bus.req0_ready, bus.req1_ready}
            !== ((w == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL contend_grant i=%0d: got %b want winner %0d",
            i, {bus.req0_ready, bus.req1_ready}, w);
        end
      end
      if (pw >= 0) begin
        checks++;
        if (load_en !== 1'b1
            || write_pointer !== address_t'(i - 1)
            || operand_a !== pe.op_a) begin
          errors++;
          $display("FAIL contend_load i=%0d: le=%b wp=%0d a=%0d want wp=%0d a=%0d",
            i, load_en, write_pointer, operand_a, i - 1, pe.op_a);
        end
      end
      if (w >= 0) begin
        pe = (w == 0) ? p0 : p1;
        m_q.push_back(pe);
      end
      pw = w;
      step();
    end
    run_sweep("contend");
  endtask

  task automatic test_full();
    int w;
    int sel;
    do_reset();
    for (int i = 0; i < INSTR_DEPTH; i++) begin
      p0 = rnd_instr();
      p1 = rnd_instr();
      sel = $urandom_range(1, 3);
      drive(sel[0], sel[1]);
      #1;
      w = m_winner(sel[0], sel[1]);
      checks++;
      if ({bus.req0_ready, bus.req1_ready}
          !== ((w == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL full_grant i=%0d: got %b want winner %0d",
          i, {bus.req0_ready, bus.req1_ready}, w);
      end
      if (i > 0) begin
        checks++;
        if (load_en !== 1'b1) begin
          errors++;
          $display("FAIL full_load_en i=%0d: got %b want 1",
            i, load_en);
        end
      end
      m_q.push_back((w == 0) ? p0 : p1);
      step();
    end
    p0 = rnd_instr();
    for (int j = 0; j < 5; j++) begin
      drive(1, 0);
      #1;
      checks++;
      if (full !== 1'b1 || count !== count_t'(INSTR_DEPTH)
          || bus.req0_ready !== 1'b0
          || load_en !== (j == 0)) begin
        errors++;
        $display("FAIL full_hold j=%0d: full=%b cnt=%0d rdy=%b le=%b",
          j, full, count, bus.req0_ready, load_en);
      end
      step();
    end
    run_sweep("full");
  endtask

  task automatic test_sweep3();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      p0 = rnd_instr();
      p0.op_a = operand_t'(10 * (i + 1));
      p1 = rnd_instr();
      drive(1, 0);
      #1;
      checks++;
      if (bus.req0_ready !== 1'b1) begin
        errors++;
        $display("FAIL sweep3_ready i=%0d: got %b want 1",
          i, bus.req0_ready);
      end
      m_q.push_back(p0);
      step();
    end
    run_sweep("sweep3");
  endtask

  task automatic test_run_conflict();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      p1 = rnd_instr();
      drive(0, 1);
      step();
    end
    drive(0, 1);
    run_start = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      errors++;
      $display("FAIL conflict_ready: got %b want 00",
        {bus.req0_ready, bus.req1_ready});
    end
    step();
    drive(0, 0);
    run_start = 1'b0;
    #1;
    checks++;
    if (load_en !== 1'b0 || busy !== 1'b1
        || count !== count_t'(2) || read_pointer !== '0) begin
      errors++;
      $display("FAIL conflict_sweep: le=%b busy=%b cnt=%0d rp=%0d",
        load_en, busy, count, read_pointer);
    end
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0
        || count !== count_t'(0) || read_pointer !== '0) begin
      errors++;
      $display("FAIL conflict_reset: busy=%b rv=%b done=%b cnt=%0d rp=%0d",
        busy, rd_valid, done, count, read_pointer);
    end
    m_q.delete();
    m_last = 1;
    step();
    run_start = 1'b1;
    step();
    run_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_run k=%0d: busy=%b done=%b rv=%b",
          k, busy, done, rd_valid);
      end
      step();
    end
  endtask

  initial begin
    p0 = '0;
    p1 = '0;
    run_start = 1'b0;
    drive(0, 0);
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_sweep3();
    test_run_conflict();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

endmodule
